instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 171 +++++++++++++++++
 tb/tb_instr_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction sequencer: walks each accepted instruction through DECODE, EXEC, an optional
// MEM phase with a 16-cycle timeout, and WB, where it issues the register and PC strobes.
module instr_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  cond,
  input  logic        s_bit,
  input  logic [1:0]  op_class,
  input  logic [3:0]  dest,
  input  logic [3:0]  alu_flags,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] reg_en,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [3:0]  flags,
  output logic        mem_err
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ALU    = 2'b00,
    OP_LOAD   = 2'b01,
    OP_STORE  = 2'b10,
    OP_BRANCH = 2'b11
  } op_t;

  localparam logic [3:0] WAIT_LAST = 4'hF;

  state_t      r_state;
  state_t      w_state_nxt;
  op_t         r_op;
  logic [3:0]  r_cond;
  logic [3:0]  r_dest;
  logic        r_s_bit;
  logic        r_pass;
  logic [3:0]  r_flags;
  logic [3:0]  r_wait;
  logic        r_timeout;

  logic        w_accept;
  logic        w_cond_pass;
  logic        w_mem_done;
  logic        w_timeout;
  logic        w_flag_wr;
  logic        w_is_mem_op;

  // Condition codes test the architectural flags as they stand at DECODE.
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: cond_pass = 1'b1;
      4'b0001: cond_pass = z;
      4'b0010: cond_pass = !z;
      4'b0011: cond_pass = cy;
      4'b0100: cond_pass = !cy;
      4'b0101: cond_pass = n;
      4'b0110: cond_pass = !n;
      4'b0111: cond_pass = v;
      4'b1000: cond_pass = !v;
      4'b1001: cond_pass = (n == v);
      4'b1010: cond_pass = (n != v);
      4'b1011: cond_pass = !z && (n == v);
      4'b1100: cond_pass = z || (n != v);
      default: cond_pass = 1'b0;
    endcase
  endfunction

  assign w_accept    = (r_state == ST_IDLE) && instr_valid;
  assign w_cond_pass = cond_pass(r_cond, r_flags);
  assign w_is_mem_op = (r_op == OP_LOAD) || (r_op == OP_STORE);
  assign w_mem_done  = mem_ack || (r_wait == WAIT_LAST);
  assign w_timeout   = (r_state == ST_MEM) && !mem_ack && (r_wait == WAIT_LAST);
  assign w_flag_wr   = (r_state == ST_EXEC) && (r_op == OP_ALU) && r_s_bit && r_pass;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always_ff blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: the default assignment first guarantees every path drives w_state_nxt,
    // so no latch can be inferred when a case arm leaves it untouched.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (instr_valid) w_state_nxt = ST_DECODE;
      ST_DECODE: w_state_nxt = w_cond_pass ? ST_EXEC : ST_WB;
      ST_EXEC:   w_state_nxt = w_is_mem_op ? ST_MEM : ST_WB;
      ST_MEM:    if (w_mem_done) w_state_nxt = ST_WB;
      ST_WB:     w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_op      <= OP_ALU;
      r_cond    <= '0;
      r_dest    <= '0;
      r_s_bit   <= 1'b0;
      r_pass    <= 1'b0;
      r_flags   <= '0;
      r_wait    <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op      <= op_t'(op_class);
        r_cond    <= cond;
        r_dest    <= dest;
        r_s_bit   <= s_bit;
        r_timeout <= 1'b0;
      end
      if (r_state == ST_DECODE) begin
        r_pass <= w_cond_pass;
      end
      if (w_flag_wr) begin
        r_flags <= alu_flags;
      end
      // The counter is zeroed on the EXEC edge so it reads 0 on the first MEM cycle.
      if (r_state == ST_EXEC) begin
        r_wait <= '0;
      end else if ((r_state == ST_MEM) && !mem_ack && (r_wait != WAIT_LAST)) begin
        r_wait <= r_wait + 4'd1;
      end
      if (w_timeout) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Outputs decode registered state only; mem_ack and instr_valid never reach them.
  always_comb begin
    instr_ready = (r_state == ST_IDLE);
    mem_req     = (r_state == ST_MEM);
    mem_we      = (r_state == ST_MEM) && (r_op == OP_STORE);
    reg_en      = '0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    mem_err     = 1'b0;
    if (r_state == ST_WB) begin
      pc_load = (r_op == OP_BRANCH) && r_pass;
      pc_inc  = !pc_load;
      mem_err = r_timeout;
      if (((r_op == OP_ALU) || (r_op == OP_LOAD)) && r_pass && !r_timeout) begin
        reg_en = 16'h0001 << r_dest;
      end
    end
  end

  assign flags = r_flags;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a table of single-instruction vectors,
// a reset-during-MEM sequence, and a full condition-code sweep via branches.
module tb_instr_sequencer;

  localparam logic [1:0] OP_ALU = 2'b00;
  localparam logic [1:0] OP_LD  = 2'b01;
  localparam logic [1:0] OP_ST  = 2'b10;
  localparam logic [1:0] OP_BR  = 2'b11;
  localparam int         TXN_BOUND = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  cond;
  logic        s_bit;
  logic [1:0]  op_class;
  logic [3:0]  dest;
  logic [3:0]  alu_flags;
  logic        mem_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] reg_en;
  logic        pc_inc;
  logic        pc_load;
  logic [3:0]  flags;
  logic        mem_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] res_reg_en;
  int          res_pc_inc;
  int          res_pc_load;
  int          res_err;
  int          res_mem;
  int          res_we;
  int          res_lat;

  typedef struct {
    logic [3:0]  init_flags;
    logic [1:0]  op;
    logic [3:0]  cnd;
    logic        s;
    logic [3:0]  dst;
    logic [3:0]  aluf;
    int          ack_at;
    logic [15:0] e_reg_en;
    int          e_pc_inc;
    int          e_pc_load;
    int          e_err;
    int          e_mem;
    int          e_we;
    logic [3:0]  e_flags;
    int          e_lat;
  } vec_t;

  instr_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .cond        (cond),
    .s_bit       (s_bit),
    .op_class    (op_class),
    .dest        (dest),
    .alu_flags   (alu_flags),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .reg_en      (reg_en),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .flags       (flags),
    .mem_err     (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int cond_model(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cf, v;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    case (c)
      4'd0:    return 1;
      4'd1:    return int'(z);
      4'd2:    return int'(!z);
      4'd3:    return int'(cf);
      4'd4:    return int'(!cf);
      4'd5:    return int'(n);
      4'd6:    return int'(!n);
      4'd7:    return int'(v);
      4'd8:    return int'(!v);
      4'd9:    return int'(n == v);
      4'd10:   return int'(n != v);
      4'd11:   return int'(!z && (n == v));
      4'd12:   return int'(z || (n != v));
      default: return 0;
    endcase
  endfunction

  // Issues one instruction and follows it back to IDLE, tallying every strobe seen.
  // While the instruction is in flight, instr_valid stays high with altered fields,
  // which the sequencer must ignore.
  task automatic run_instr(input logic [1:0] op, input logic [3:0] c, input logic s,
                           input logic [3:0] d, input logic [3:0] af, input int ack_at);
    int waited;
    waited      = 0;
    res_reg_en  = '0;
    res_pc_inc  = 0;
    res_pc_load = 0;
    res_err     = 0;
    res_mem     = 0;
    res_we      = 0;
    res_lat     = 0;
    alu_flags   = af;
    mem_ack     = 1'b0;
    while (!instr_ready && waited < TXN_BOUND) begin
      tick();
      waited++;
    end
    if (!instr_ready) begin
      check("ready_bound", 32'(instr_ready), 32'd1);
      return;
    end
    instr_valid = 1'b1;
    op_class    = op;
    cond        = c;
    s_bit       = s;
    dest        = d;
    tick();
    res_lat     = 1;
    op_class    = ~op;
    cond        = ~c;
    s_bit       = ~s;
    dest        = ~d;
    while (!instr_ready) begin
      if (mem_req) begin
        res_mem++;
        if (mem_we) res_we = 1;
      end
      mem_ack      = mem_req && (ack_at != 0) && (res_mem == ack_at);
      res_reg_en  |= reg_en;
      res_pc_inc  += int'(pc_inc);
      res_pc_load += int'(pc_load);
      res_err     += int'(mem_err);
      if (res_lat >= TXN_BOUND) begin
        check("txn_bound", 32'(res_lat), 32'd0);
        break;
      end
      tick();
      res_lat++;
    end
    instr_valid = 1'b0;
    mem_ack     = 1'b0;
  endtask

  task automatic set_flags(input logic [3:0] f);
    run_instr(OP_ALU, 4'b0000, 1'b1, 4'd0, f, 0);
    check("set_flags", 32'(flags), 32'(f));
  endtask

  initial begin
    vec_t vecs[15];
    int   waited;
    logic [4:0] seen;

    vecs[0]  = '{4'b0000, OP_ALU, 4'b0000, 1'b1, 4'd5,  4'b0100, 0,  16'h0020, 1, 0, 0, 0,  0, 4'b0100, 4};
    vecs[1]  = '{4'b0100, OP_ALU, 4'b0010, 1'b1, 4'd3,  4'b1000, 0,  16'h0000, 1, 0, 0, 0,  0, 4'b0100, 3};
    vecs[2]  = '{4'b0000, OP_LD,  4'b0000, 1'b1, 4'd15, 4'b1111, 3,  16'h8000, 1, 0, 0, 3,  0, 4'b0000, 7};
    vecs[3]  = '{4'b0000, OP_ST,  4'b0000, 1'b0, 4'd7,  4'b0000, 0,  16'h0000, 1, 0, 1, 16, 1, 4'b0000, 20};
    vecs[4]  = '{4'b1001, OP_BR,  4'b1001, 1'b0, 4'd4,  4'b0000, 0,  16'h0000, 0, 1, 0, 0,  0, 4'b1001, 4};
    vecs[5]  = '{4'b1001, OP_BR,  4'b1010, 1'b0, 4'd4,  4'b0000, 0,  16'h0000, 1, 0, 0, 0,  0, 4'b1001, 3};
    vecs[6]  = '{4'b0010, OP_LD,  4'b0011, 1'b0, 4'd1,  4'b0000, 1,  16'h0002, 1, 0, 0, 1,  0, 4'b0010, 5};
    vecs[7]  = '{4'b0000, OP_LD,  4'b0000, 1'b0, 4'd2,  4'b0000, 16, 16'h0004, 1, 0, 0, 16, 0, 4'b0000, 20};
    vecs[8]  = '{4'b0000, OP_ST,  4'b0000, 1'b0, 4'd6,  4'b0000, 2,  16'h0000, 1, 0, 0, 2,  1, 4'b0000, 6};
    vecs[9]  = '{4'b0011, OP_ALU, 4'b0000, 1'b0, 4'd9,  4'b1111, 0,  16'h0200, 1, 0, 0, 0,  0, 4'b0011, 4};
    vecs[10] = '{4'b0000, OP_ALU, 4'b1111, 1'b1, 4'd8,  4'b1111, 0,  16'h0000, 1, 0, 0, 0,  0, 4'b0000, 3};
    vecs[11] = '{4'b0000, OP_LD,  4'b0000, 1'b0, 4'd11, 4'b0000, 0,  16'h0000, 1, 0, 1, 16, 0, 4'b0000, 20};
    vecs[12] = '{4'b1000, OP_LD,  4'b0001, 1'b0, 4'd4,  4'b0000, 3,  16'h0000, 1, 0, 0, 0,  0, 4'b1000, 3};
    vecs[13] = '{4'b0001, OP_ALU, 4'b1100, 1'b1, 4'd0,  4'b1010, 0,  16'h0001, 1, 0, 0, 0,  0, 4'b1010, 4};
    vecs[14] = '{4'b0000, OP_BR,  4'b0000, 1'b1, 4'd3,  4'b1111, 0,  16'h0000, 0, 1, 0, 0,  0, 4'b0000, 4};

    reset       = 1'b1;
    instr_valid = 1'b0;
    cond        = '0;
    s_bit       = 1'b0;
    op_class    = '0;
    dest        = '0;
    alu_flags   = '0;
    mem_ack     = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    check("rst_instr_ready", 32'(instr_ready), 32'd1);
    check("rst_mem_req",     32'(mem_req),     32'd0);
    check("rst_mem_we",      32'(mem_we),      32'd0);
    check("rst_reg_en",      32'(reg_en),      32'd0);
    check("rst_pc_inc",      32'(pc_inc),      32'd0);
    check("rst_pc_load",     32'(pc_load),     32'd0);
    check("rst_mem_err",     32'(mem_err),     32'd0);
    check("rst_flags",       32'(flags),       32'd0);

    for (int i = 0; i < 15; i++) begin
      set_flags(vecs[i].init_flags);
      run_instr(vecs[i].op, vecs[i].cnd, vecs[i].s, vecs[i].dst, vecs[i].aluf, vecs[i].ack_at);
      check($sformatf("v%0d_reg_en",  i), 32'(res_reg_en),  32'(vecs[i].e_reg_en));
      check($sformatf("v%0d_pc_inc",  i), 32'(res_pc_inc),  32'(vecs[i].e_pc_inc));
      check($sformatf("v%0d_pc_load", i), 32'(res_pc_load), 32'(vecs[i].e_pc_load));
      check($sformatf("v%0d_mem_err", i), 32'(res_err),     32'(vecs[i].e_err));
      check($sformatf("v%0d_mem_req", i), 32'(res_mem),     32'(vecs[i].e_mem));
      check($sformatf("v%0d_mem_we",  i), 32'(res_we),      32'(vecs[i].e_we));
      check($sformatf("v%0d_flags",   i), 32'(flags),       32'(vecs[i].e_flags));
      check($sformatf("v%0d_latency", i), 32'(res_lat),     32'(vecs[i].e_lat));
    end

    // Reset in the third MEM cycle of a load must abandon it without any side effect.
    set_flags(4'b0110);
    instr_valid = 1'b1;
    op_class    = OP_LD;
    cond        = 4'b0000;
    s_bit       = 1'b0;
    dest        = 4'd5;
    tick();
    instr_valid = 1'b0;
    waited      = 0;
    while (!mem_req && waited < 10) begin
      tick();
      waited++;
    end
    check("mr_reached_mem", 32'(mem_req), 32'd1);
    tick();
    tick();
    check("mr_still_mem", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_instr_ready", 32'(instr_ready), 32'd1);
    check("mr_mem_req",     32'(mem_req),     32'd0);
    check("mr_flags",       32'(flags),       32'd0);
    check("mr_reg_en",      32'(reg_en),      32'd0);
    check("mr_pc_inc",      32'(pc_inc),      32'd0);
    seen    = '0;
    mem_ack = 1'b1;
    repeat (20) begin
      seen |= {reg_en != 16'h0, pc_inc, pc_load, mem_err, mem_req};
      tick();
    end
    mem_ack = 1'b0;
    check("mr_quiet", 32'(seen), 32'd0);
    run_instr(OP_ALU, 4'b0000, 1'b0, 4'd1, 4'b0000, 0);
    check("mr_resume_reg_en",  32'(res_reg_en), 32'h0002);
    check("mr_resume_latency", 32'(res_lat),    32'd4);

    // Every condition code against every flag value, observed through branch strobes.
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        run_instr(OP_BR, 4'(c), 1'b0, 4'd0, 4'b0000, 0);
        check($sformatf("sweep_f%0h_c%0h", f, c), 32'(res_pc_load), 32'(cond_model(4'(c), 4'(f))));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
